vga_timing_gen: RTL and testbench

- Pixel-timing source that drives the sprite renderer. It produces DrawX/DrawY/blank plus delayed hs/vs for the VGA pins.
- Accepts Fireboy/Watergirl sprite positions from game logic over a valid/ready handshake, but only during vertical blanking.
- Commits accepted positions atomically at the frame boundary, so the renderer never sees a position change mid-frame.
- Sits between the game/physics logic and the renderer's FireX/FireY/BallX/BallY inputs.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_timing_gen_if.sv | 11 +
 rtl/sync_delay_line.sv | 21 ++
 rtl/vga_timing_gen.sv | 80 ++++++++
 tb/tb_vga_timing_gen.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and the sprite position set type
package vga_timing_pkg;
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START  = H_VISIBLE + H_FRONT;
   localparam int HS_END    = HS_START + H_SYNC - 1;
   localparam int VS_START  = V_VISIBLE + V_FRONT;
   localparam int VS_END    = VS_START + V_SYNC - 1;
   typedef struct packed {
      logic [9:0] fire_x;
      logic [9:0] fire_y;
      logic [9:0] ball_x;
      logic [9:0] ball_y;
   } pos_set_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: valid/ready position offer from game logic to the timing generator
interface vga_timing_gen_if;
   logic       pos_valid;
   logic       pos_ready;
   logic [9:0] fire_x_in;
   logic [9:0] fire_y_in;
   logic [9:0] ball_x_in;
   logic [9:0] ball_y_in;
   modport master (output pos_valid, fire_x_in, fire_y_in, ball_x_in, ball_y_in, input pos_ready);
   modport slave  (input pos_valid, fire_x_in, fire_y_in, ball_x_in, ball_y_in, output pos_ready);
endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: N-stage shift register resetting to 1 (idle level of active-low syncs)
module sync_delay_line #(
   parameter int N = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   if (N == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q = i_d;
   end else begin : g_sr
      logic [N-1:0] r_sr;
      always_ff @(posedge clk)
         if (rst) r_sr <= '1;
         else r_sr <= N'({r_sr, i_d});
      assign o_q = r_sr[N-1];
   end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel counters, delayed syncs and frame-atomic sprite position registers
module vga_timing_gen #(
   parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
   parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int H_BACK     = vga_timing_pkg::H_BACK,
   parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
   parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int V_BACK     = vga_timing_pkg::V_BACK,
   parameter int SYNC_DELAY = 1
) (
   input  logic             vga_clk,
   input  logic             reset,
   vga_timing_gen_if.slave  pos,
   output logic [9:0]       DrawX,
   output logic [9:0]       DrawY,
   output logic             blank,
   output logic             hs,
   output logic             vs,
   output logic             frame_start,
   output logic [9:0]       FireX,
   output logic [9:0]       FireY,
   output logic [9:0]       BallX,
   output logic [9:0]       BallY
);
   import vga_timing_pkg::*;
   localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   if (H_TOT >= 1024 || V_TOT >= 1024 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_params
      $error("vga_timing_gen: totals must be below 1024 and SYNC_DELAY within 0..4");
   end
   logic [9:0] r_hc, r_vc;
   logic       r_pend_full;
   pos_set_t   r_pend, r_pos;
   logic       w_h_end, w_commit, w_xfer, w_hs_raw, w_vs_raw;
   assign w_h_end       = r_hc == H_LAST;
   assign w_commit      = w_h_end && r_vc == V_LAST;
   // Holding ready low on the commit cycle keeps accept and commit mutually exclusive
   assign pos.pos_ready = r_vc >= V_VIS && !w_commit;
   assign w_xfer        = pos.pos_valid && pos.pos_ready;
   assign w_hs_raw      = !(r_hc >= HS_LO && r_hc <= HS_HI);
   assign w_vs_raw      = !(r_vc >= VS_LO && r_vc <= VS_HI);
   assign DrawX         = r_hc;
   assign DrawY         = r_vc;
   assign blank         = r_hc < H_VIS && r_vc < V_VIS;
   assign frame_start   = r_hc == '0 && r_vc == '0;
   assign FireX         = r_pos.fire_x;
   assign FireY         = r_pos.fire_y;
   assign BallX         = r_pos.ball_x;
   assign BallY         = r_pos.ball_y;
   always_ff @(posedge vga_clk)
      if (reset) begin
         r_hc        <= '0;
         r_vc        <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
         r_pos       <= '0;
      end else begin
         r_hc <= w_h_end ? '0 : r_hc + 10'd1;
         if (w_h_end) r_vc <= w_commit ? '0 : r_vc + 10'd1;
         if (w_xfer) begin
            r_pend      <= {pos.fire_x_in, pos.fire_y_in, pos.ball_x_in, pos.ball_y_in};
            r_pend_full <= 1'b1;
         end else if (w_commit && r_pend_full) begin
            r_pos       <= r_pend;
            r_pend_full <= 1'b0;
         end
      end
   sync_delay_line #(.N(SYNC_DELAY)) u_hs_dly (.clk(vga_clk), .rst(reset), .i_d(w_hs_raw), .o_q(hs));
   sync_delay_line #(.N(SYNC_DELAY)) u_vs_dly (.clk(vga_clk), .rst(reset), .i_d(w_vs_raw), .o_q(vs));
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random and directed position offers against a time-indexed reference model
module tb_vga_timing_gen;
   localparam int HV = 16, HF = 4, HSW = 6, HB = 4, HT = HV + HF + HSW + HB;
   localparam int VV = 12, VF = 2, VSW = 2, VB = 3, VT = VV + VF + VSW + VB;
   localparam int FT = HT * VT;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   vga_timing_gen_if pif(), pif0(), pif3();
   logic [9:0] dx, dy, fx, fy, bx, by, dx0, dy0, fx0, fy0, bx0, by0, dx3, dy3, fx3, fy3, bx3, by3;
   logic       blank, hs, vs, fs, blank0, hs0, vs0, fs0, blank3, hs3, vs3, fs3;
   vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .SYNC_DELAY(1)) dut (
      .vga_clk(clk), .reset(rst), .pos(pif), .DrawX(dx), .DrawY(dy), .blank(blank), .hs(hs), .vs(vs),
      .frame_start(fs), .FireX(fx), .FireY(fy), .BallX(bx), .BallY(by));
   vga_timing_gen #(.SYNC_DELAY(0)) d0 (
      .vga_clk(clk), .reset(rst), .pos(pif0), .DrawX(dx0), .DrawY(dy0), .blank(blank0), .hs(hs0), .vs(vs0),
      .frame_start(fs0), .FireX(fx0), .FireY(fy0), .BallX(bx0), .BallY(by0));
   vga_timing_gen #(.SYNC_DELAY(3)) d3 (
      .vga_clk(clk), .reset(rst), .pos(pif3), .DrawX(dx3), .DrawY(dy3), .blank(blank3), .hs(hs3), .vs(vs3),
      .frame_start(fs3), .FireX(fx3), .FireY(fy3), .BallX(bx3), .BallY(by3));
   int n_chk = 0, n_pass = 0;
   int t, pend_full, pend[4], com[4], od[4];
   bit acc = 0;
   logic p0 = 1'b1, p3 = 1'b1;
   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
   endtask
   function automatic int mh(input int tt); return tt % HT; endfunction
   function automatic int mv(input int tt); return (tt / HT) % VT; endfunction
   function automatic int hs_exp(input int tt, input int d, input int ht, input int lo, input int w);
      int h;
      if (tt < d) return 1;
      h = (tt - d) % ht;
      return (h >= lo && h < lo + w) ? 0 : 1;
   endfunction
   function automatic int vs_exp(input int tt, input int d, input int ht, input int vt, input int lo, input int w);
      int v;
      if (tt < d) return 1;
      v = ((tt - d) / ht) % vt;
      return (v >= lo && v < lo + w) ? 0 : 1;
   endfunction
   task automatic check_all();
      int h, v;
      h = mh(t);
      v = mv(t);
      chk("drawx", dx, h);
      chk("drawy", dy, v);
      chk("blank", blank, int'(h < HV && v < VV));
      chk("hs", hs, hs_exp(t, 1, HT, HV + HF, HSW));
      chk("vs", vs, vs_exp(t, 1, HT, VT, VV + VF, VSW));
      chk("frame_start", fs, int'(h == 0 && v == 0));
      chk("pos_ready", pif.pos_ready, int'(v >= VV && !(h == HT - 1 && v == VT - 1)));
      chk("firex", fx, com[0]);
      chk("firey", fy, com[1]);
      chk("ballx", bx, com[2]);
      chk("bally", by, com[3]);
      chk("d0_hs", hs0, hs_exp(t, 0, 800, 656, 96));
      chk("d0_vs", vs0, vs_exp(t, 0, 800, 525, 490, 2));
      chk("d3_hs", hs3, hs_exp(t, 3, 800, 656, 96));
      chk("d3_vs", vs3, vs_exp(t, 3, 800, 525, 490, 2));
      if (p0 && !hs0) chk("d0_hs_fall_hc", t % 800, 656);
      if (p3 && !hs3) chk("d3_hs_fall_hc", t % 800, 659);
      p0 = hs0;
      p3 = hs3;
   endtask
   task automatic offer(input int fire_x);
      od[0] = fire_x;
      for (int i = 1; i < 4; i++) od[i] = int'($urandom_range(1023, 0));
      pif.fire_x_in = 10'(od[0]);
      pif.fire_y_in = 10'(od[1]);
      pif.ball_x_in = 10'(od[2]);
      pif.ball_y_in = 10'(od[3]);
      pif.pos_valid = 1'b1;
      acc = 0;
   endtask
   task automatic cycle();
      bit commit;
      if (acc) begin
         pif.pos_valid = 1'b0;
         acc = 0;
      end
      if (rst) begin
         t = 0;
         pend_full = 0;
         for (int i = 0; i < 4; i++) begin pend[i] = 0; com[i] = 0; end
      end else begin
         commit = mh(t) == HT - 1 && mv(t) == VT - 1;
         if (commit && pend_full != 0) begin com = pend; pend_full = 0; end
         if (pif.pos_valid && mv(t) >= VV && !commit) begin pend = od; pend_full = 1; acc = 1; end
         t++;
      end
      @(negedge clk);
      check_all();
   endtask
   task automatic run_until(input int h, input int v);
      for (int i = 0; i < 2 * FT && !(mh(t) == h && mv(t) == v); i++) cycle();
   endtask
   initial begin
      pif.pos_valid = 1'b0;
      pif.fire_x_in = '0; pif.fire_y_in = '0; pif.ball_x_in = '0; pif.ball_y_in = '0;
      pif0.pos_valid = 1'b0;
      pif0.fire_x_in = '0; pif0.fire_y_in = '0; pif0.ball_x_in = '0; pif0.ball_y_in = '0;
      pif3.pos_valid = 1'b0;
      pif3.fire_x_in = '0; pif3.fire_y_in = '0; pif3.ball_x_in = '0; pif3.ball_y_in = '0;
      t = 0;
      pend_full = 0;
      for (int i = 0; i < 4; i++) begin pend[i] = 0; com[i] = 0; od[i] = 0; end
      repeat (3) @(negedge clk);
      check_all();
      chk("reset_frame_start", fs, 1);
      chk("reset_blank", blank, 1);
      rst = 1'b0;
      run_until(10, 5);
      offer(300);
      chk("rdy_visible", pif.pos_ready, 0);
      run_until(HT - 1, VV - 1);
      chk("blank_corner_last_vis", blank, 0);
      cycle();
      chk("blank_vblank_start", blank, 0);
      chk("rdy_vblank_start", pif.pos_ready, 1);
      chk("firex_hold_300", fx, 0);
      run_until(HT - 1, VT - 1);
      chk("rdy_commit_cycle", pif.pos_ready, 0);
      chk("firex_pre_commit", fx, 0);
      cycle();
      chk("frame_start_wrap", fs, 1);
      chk("blank_wrap", blank, 1);
      chk("firex_commit_300", fx, 300);
      run_until(0, VV);
      offer(50);
      cycle();
      cycle();
      offer(60);
      run_until(0, 0);
      chk("firex_last_wins", fx, 60);
      cycle();
      run_until(0, 0);
      chk("firex_idle_vblank", fx, 60);
      run_until(0, VV);
      offer(77);
      repeat (3) cycle();
      run_until(0, 14);
      rst = 1'b1;
      pif.pos_valid = 1'b0;
      acc = 0;
      cycle();
      cycle();
      chk("firex_after_reset", fx, 0);
      chk("drawy_after_reset", dy, 0);
      chk("rdy_after_reset", pif.pos_ready, 0);
      rst = 1'b0;
      cycle();
      run_until(0, 0);
      chk("firex_no_stale_commit", fx, 0);
      for (int i = 0; i < 6 * FT; i++) begin
         if (!pif.pos_valid && $urandom_range(39, 0) == 0) offer(int'($urandom_range(1023, 0)));
         rst = $urandom_range(1499, 0) == 0;
         cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
